// File: rtl/alu_exec_sequencer_if.sv
// Bundle of the sequencer's command handshake and register-file port.
// The slave side is the sequencer; the master side is its requester plus
// the register file that supplies operands and accepts the writeback.
interface alu_exec_sequencer_if #(
  parameter int W = 16
);
  logic         start;
  logic [1:0]   alu_op;
  logic [1:0]   shift;
  logic [2:0]   rn;
  logic [2:0]   rm;
  logic [2:0]   rd;
  logic         wb;
  logic [W-1:0] rf_data_out;
  logic [2:0]   rf_readnum;
  logic [2:0]   rf_writenum;
  logic         rf_write;
  logic [W-1:0] rf_data_in;
  logic         busy;
  logic         done;
  logic [2:0]   status;

  modport slave (
    input  start, alu_op, shift, rn, rm, rd, wb, rf_data_out,
    output rf_readnum, rf_writenum, rf_write, rf_data_in, busy, done, status
  );

  modport master (
    output start, alu_op, shift, rn, rm, rd, wb, rf_data_out,
    input  rf_readnum, rf_writenum, rf_write, rf_data_in, busy, done, status
  );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute stage: reads A and B from the register file over two
// cycles, shifts B, runs the ALU into C with {Z,N,V}, then writes C back.
// One operation every five cycles under a start/done handshake.
module alu_exec_sequencer #(
  parameter int W = 16
) (
  input logic                clk,
  input logic                reset_n,
  alu_exec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_nxt;

  logic [1:0]   alu_op_q;
  logic [1:0]   shift_q;
  logic [2:0]   rn_q;
  logic [2:0]   rm_q;
  logic [2:0]   rd_q;
  logic         wb_q;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] c_q;
  logic [2:0]   status_q;

  logic [W-1:0] b_sh;
  logic [W-1:0] result;
  logic         v_flag;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: fixed walk through the five states, gated by start.
  // NOTE: next-state is given a default before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nxt = S_LOAD_A;
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command capture and datapath registers; each loads only in its own state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op_q <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            alu_op_q <= bus.alu_op;
            shift_q  <= bus.shift;
            rn_q     <= bus.rn;
            rm_q     <= bus.rm;
            rd_q     <= bus.rd;
            wb_q     <= bus.wb;
          end
        end
        S_LOAD_A: a_q <= bus.rf_data_out;
        S_LOAD_B: b_q <= bus.rf_data_out;
        S_EXEC: begin
          c_q      <= result;
          status_q <= {(result == '0), result[W-1], v_flag};
        end
        default: ;
      endcase
    end
  end

  // Barrel-free one-bit shifter forming B'.
  always_comb begin
    b_sh = b_q;
    unique case (shift_q)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[W-2:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[W-1:1]};
      2'b11: b_sh = {b_q[W-1], b_q[W-1:1]};
      default: b_sh = b_q;
    endcase
  end

  // ALU and signed-overflow detect; carry out is intentionally dropped.
  always_comb begin
    result = '0;
    v_flag = 1'b0;
    unique case (alu_op_q)
      OP_ADD: begin
        result = a_q + b_sh;
        v_flag = (a_q[W-1] == b_sh[W-1]) && (result[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        result = a_q + ~b_sh + ONE;
        v_flag = (a_q[W-1] != b_sh[W-1]) && (result[W-1] != a_q[W-1]);
      end
      OP_AND: result = a_q & b_sh;
      OP_MVN: result = ~b_sh;
      default: result = '0;
    endcase
  end

  // Register-file read select follows the load state; zero otherwise.
  always_comb begin
    bus.rf_readnum = 3'd0;
    unique case (state)
      S_LOAD_A: bus.rf_readnum = rn_q;
      S_LOAD_B: bus.rf_readnum = rm_q;
      default:  bus.rf_readnum = 3'd0;
    endcase
  end

  // Remaining outputs decode directly from registers, so they are glitch-free
  // and drop the instant reset forces the state back to IDLE.
  assign bus.rf_writenum = rd_q;
  assign bus.rf_write    = (state == S_WB) && wb_q;
  assign bus.rf_data_in  = c_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_WB);
  assign bus.status      = status_q;

endmodule
